multicycle_control_unit: RTL and testbench
==========================================

Name: multicycle_control_unit

Overview:
- Moore-style FSM that sequences the multicycle MIPS-subset datapath through IF/ID/EXE/MEM/WB.
- Drives every datapath control line, including the 2-bit selection of the 4-way 5-bit destination-register selector: DataA=5'd31, DataB=rt, DataC=rd, DataD unused.
- Sits between the instruction register (opcode, held stable by IRWre) and the PC, register file, ALU, extender, memories and muxes.

Parameters:
STATE_W, 3, width of State output (fixed; encodings below)

Ports:
CLK  input  1  system clock, rising edge
Reset  input  1  synchronous, active-high; forces sIF
Opcode  input  6  IR[31:26], stable from sID until next sIF
Zero  input  1  ALU result == 0
PCWre  output  1  PC load enable
IRWre  output  1  IR load enable
InsMemRW  output  1  1 = instruction memory read
RegWre  output  1  register file write enable
WrRegData  output  1  0 = PC+4, 1 = DB (ALU/memory)
RegDst  output  2  destination selector: 0 = $31, 1 = rt, 2 = rd; 3 never driven
ExtSel  output  1  0 = zero-extend, 1 = sign-extend
ALUSrcB  output  1  0 = rt data, 1 = extended immediate
ALUOp  output  3  000 add, 001 sub, 011 or, 110 slt
DataMemRW  output  1  0 = read, 1 = write
DBDataSrc  output  1  0 = ALU result, 1 = data memory
PCSrc  output  2  00 PC+4, 01 PC+4+(imm<<2), 10 jump target
State  output  3  current state

Behaviour:
- Opcodes: add 000000, sub 000001, ori 010000, slt 100110, sw 110000, lw 110001, beq 110100, j 111000, jal 111010, halt 111111. Any other opcode is an illegal opcode.
- State encoding: sIF=000, sID=001, sEXE_AL=110, sEXE_BR=101, sEXE_LS=010, sMEM=011, sWB_AL=111, sWB_LD=100.
- State register updates on the rising edge of CLK. All control outputs are combinational from State and Opcode only. No Zero-dependent output except PCSrc in sEXE_BR.
- Reset high at any edge: State <= sIF, including mid-instruction. While in sIF or under reset, outputs take the sIF values below.

Transitions:
- sIF -> sID
- sID -> sEXE_AL for add/sub/ori/slt
- sID -> sEXE_BR for beq
- sID -> sEXE_LS for sw/lw
- sID -> sIF for j/jal/halt/illegal opcode
- sEXE_AL -> sWB_AL -> sIF
- sEXE_BR -> sIF
- sEXE_LS -> sMEM
- sMEM -> sWB_LD for lw; sMEM -> sIF for sw
- sWB_LD -> sIF

Per-state outputs (unlisted outputs default to 0; RegDst defaults to 1, ExtSel to 1, PCSrc to 00):
- sIF: InsMemRW=1, IRWre=1.
- sID, j: PCSrc=10, PCWre=1.
- sID, jal: PCSrc=10, PCWre=1, RegWre=1, RegDst=0, WrRegData=0 ($31 <= PC+4).
- sID, halt: PCWre=0, so the PC freezes and the same halt is re-fetched indefinitely.
- sID, illegal opcode: PCWre=1, PCSrc=00 (executes as a nop).
- sEXE_AL:
  - ALUSrcB=1 for ori, else 0.
  - ExtSel=0 for ori.
  - ALUOp: add 000, sub 001, ori 011, slt 110.
- sWB_AL: RegWre=1, WrRegData=1, DBDataSrc=0, PCWre=1, RegDst=1 for ori and 2 for add/sub/slt. Keep ALUSrcB, ExtSel and ALUOp identical to sEXE_AL so the ALU result is held.
- sEXE_BR: ALUOp=001, ALUSrcB=0, PCWre=1, PCSrc=01 if Zero else 00.
- sEXE_LS: ALUOp=000, ALUSrcB=1, ExtSel=1.
- sMEM: same ALU controls as sEXE_LS. DataMemRW=1 and PCWre=1 for sw; DataMemRW=0 for lw.
- sWB_LD: RegWre=1, RegDst=1, WrRegData=1, DBDataSrc=1, PCWre=1, ALU controls held.

Invariants:
- PCWre is high in exactly one cycle per completed instruction: the final state before sIF.
- RegWre is never high outside sID(jal), sWB_AL and sWB_LD.
- DataMemRW is high only in sMEM for sw.

Test Plan:
- Reset high 2 cycles mid-sMEM of lw -> next edge State=000; IRWre=1, InsMemRW=1; RegWre=0, PCWre=0.
- Opcode 000000 (add) from reset -> states 000,001,110,111,000; in sWB_AL RegWre=1, RegDst=2, DBDataSrc=0, PCWre=1; 4 cycles per instruction.
- Opcode 110001 (lw) -> states 000,001,010,011,100,000; sWB_LD RegDst=1, DBDataSrc=1, RegWre=1. Opcode 110000 (sw) -> ends at sMEM with DataMemRW=1, PCWre=1, RegWre=0.
- Opcode 110100 (beq) with Zero=1 -> sEXE_BR PCSrc=01, ALUOp=001; with Zero=0 -> PCSrc=00; both take 3 cycles and PCWre=1.
- Opcode 111010 (jal) -> sID RegWre=1, RegDst=0, WrRegData=0, PCSrc=10, PCWre=1. Opcode 010000 (ori) -> sWB_AL RegDst=1, ExtSel=0, ALUSrcB=1, ALUOp=011.
- Opcode 111111 (halt) for 10 cycles -> State alternates 000/001 and PCWre stays 0. Opcode 101010 (illegal) -> sID PCWre=1, PCSrc=00, RegWre=0.

Source files
------------

// File: rtl/multicycle_control_unit_if.sv
// multicycle_control_unit_if: control bus between the multicycle control unit and its datapath.
// Ports: Opcode/Zero come from the datapath (IR[31:26], ALU zero flag);
// every other signal is a datapath control line plus the current State.
// master = control unit side, slave = datapath side.
interface multicycle_control_unit_if #(parameter int STATE_W = 3);
    logic [5:0]         Opcode;
    logic               Zero;
    logic               PCWre;
    logic               IRWre;
    logic               InsMemRW;
    logic               RegWre;
    logic               WrRegData;
    logic [1:0]         RegDst;
    logic               ExtSel;
    logic               ALUSrcB;
    logic [2:0]         ALUOp;
    logic               DataMemRW;
    logic               DBDataSrc;
    logic [1:0]         PCSrc;
    logic [STATE_W-1:0] State;
    modport master (
        input  Opcode, Zero,
        output PCWre, IRWre, InsMemRW, RegWre, WrRegData, RegDst, ExtSel,
               ALUSrcB, ALUOp, DataMemRW, DBDataSrc, PCSrc, State
    );
    modport slave (
        output Opcode, Zero,
        input  PCWre, IRWre, InsMemRW, RegWre, WrRegData, RegDst, ExtSel,
               ALUSrcB, ALUOp, DataMemRW, DBDataSrc, PCSrc, State
    );
endinterface

// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit: Moore FSM sequencing a multicycle MIPS-subset datapath through IF/ID/EXE/MEM/WB.
// Ports: CLK (rising edge), Reset (sync, active-high, forces sIF),
// bus (master modport): Opcode/Zero in, all datapath control lines and State out.
module multicycle_control_unit #(parameter int STATE_W = 3) (
    input  logic                      CLK,
    input  logic                      Reset,
    multicycle_control_unit_if.master bus
);
    typedef enum logic [2:0] {
        sIF     = 3'b000,
        sID     = 3'b001,
        sEXE_AL = 3'b110,
        sEXE_BR = 3'b101,
        sEXE_LS = 3'b010,
        sMEM    = 3'b011,
        sWB_AL  = 3'b111,
        sWB_LD  = 3'b100
    } state_t;
    state_t state, nextState, decState;
    logic isAdd, isSub, isOri, isSlt, isSw, isLw, isBeq, isJ, isJal, isHalt, isAl, isLs;
    logic [2:0] alOp;
    assign isAdd  = bus.Opcode == 6'b000000;
    assign isSub  = bus.Opcode == 6'b000001;
    assign isOri  = bus.Opcode == 6'b010000;
    assign isSlt  = bus.Opcode == 6'b100110;
    assign isSw   = bus.Opcode == 6'b110000;
    assign isLw   = bus.Opcode == 6'b110001;
    assign isBeq  = bus.Opcode == 6'b110100;
    assign isJ    = bus.Opcode == 6'b111000;
    assign isJal  = bus.Opcode == 6'b111010;
    assign isHalt = bus.Opcode == 6'b111111;
    assign isAl   = isAdd | isSub | isOri | isSlt;
    assign isLs   = isSw | isLw;
    assign alOp   = isSub ? 3'b001 : isOri ? 3'b011 : isSlt ? 3'b110 : 3'b000;
    // Outputs show the fetch values while Reset is held, even before the register has returned to sIF.
    assign decState  = Reset ? sIF : state;
    assign bus.State = STATE_W'(state);
    always_ff @(posedge CLK) begin
        state <= Reset ? sIF : nextState;
    end
    always_comb begin
        nextState     = sIF;
        bus.PCWre     = 1'b0;
        bus.IRWre     = 1'b0;
        bus.InsMemRW  = 1'b0;
        bus.RegWre    = 1'b0;
        bus.WrRegData = 1'b0;
        bus.RegDst    = 2'd1;
        bus.ExtSel    = 1'b1;
        bus.ALUSrcB   = 1'b0;
        bus.ALUOp     = 3'b000;
        bus.DataMemRW = 1'b0;
        bus.DBDataSrc = 1'b0;
        bus.PCSrc     = 2'b00;
        case (decState)
            sIF: begin
                nextState    = sID;
                bus.IRWre    = 1'b1;
                bus.InsMemRW = 1'b1;
            end
            sID: begin
                nextState  = isAl ? sEXE_AL : isBeq ? sEXE_BR : isLs ? sEXE_LS : sIF;
                // j/jal/illegal retire here; halt keeps the PC so it is re-fetched forever.
                bus.PCWre  = !(isAl | isBeq | isLs | isHalt);
                bus.PCSrc  = (isJ | isJal) ? 2'b10 : 2'b00;
                bus.RegWre = isJal;
                bus.RegDst = isJal ? 2'd0 : 2'd1;
            end
            sEXE_AL: begin
                nextState   = sWB_AL;
                bus.ALUSrcB = isOri;
                bus.ExtSel  = !isOri;
                bus.ALUOp   = alOp;
            end
            sWB_AL: begin
                bus.ALUSrcB   = isOri;
                bus.ExtSel    = !isOri;
                bus.ALUOp     = alOp;
                bus.RegWre    = 1'b1;
                bus.WrRegData = 1'b1;
                bus.PCWre     = 1'b1;
                bus.RegDst    = isOri ? 2'd1 : 2'd2;
            end
            sEXE_BR: begin
                bus.ALUOp = 3'b001;
                bus.PCWre = 1'b1;
                bus.PCSrc = bus.Zero ? 2'b01 : 2'b00;
            end
            sEXE_LS: begin
                nextState   = sMEM;
                bus.ALUSrcB = 1'b1;
            end
            sMEM: begin
                nextState     = isLw ? sWB_LD : sIF;
                bus.ALUSrcB   = 1'b1;
                bus.DataMemRW = isSw;
                bus.PCWre     = !isLw;
            end
            sWB_LD: begin
                bus.ALUSrcB   = 1'b1;
                bus.RegWre    = 1'b1;
                bus.WrRegData = 1'b1;
                bus.DBDataSrc = 1'b1;
                bus.PCWre     = 1'b1;
            end
            default: nextState = sIF;
        endcase
    end
endmodule

// File: tb/tb_multicycle_control_unit.sv
// tb_multicycle_control_unit: scoreboard bench; per-instruction expected cycles are queued, a negedge monitor compares.
module tb_multicycle_control_unit;
    typedef struct packed {
        logic [2:0] st;
        logic       pcWre, irWre, insMemRw, regWre, wrRegData;
        logic [1:0] regDst;
        logic       extSel, aluSrcB;
        logic [2:0] aluOp;
        logic       dataMemRw, dbDataSrc;
        logic [1:0] pcSrc;
    } ctrl_t;

    logic CLK = 1'b0;
    logic Reset = 1'b1;
    int checks = 0;
    int errors = 0;
    ctrl_t q[$];
    ctrl_t seq[$];

    multicycle_control_unit_if #(.STATE_W(3)) bus();
    multicycle_control_unit #(.STATE_W(3)) dut (.CLK(CLK), .Reset(Reset), .bus(bus));

    always #5 CLK = ~CLK;

    localparam logic [5:0] ADD = 6'b000000, SUB = 6'b000001, ORI = 6'b010000, SLT = 6'b100110,
                           SW = 6'b110000, LW = 6'b110001, BEQ = 6'b110100, J = 6'b111000,
                           JAL = 6'b111010, HALT = 6'b111111;

    function automatic ctrl_t idle(input logic [2:0] st);
        ctrl_t c = '0;
        c.st = st;
        c.regDst = 2'd1;
        c.extSel = 1'b1;
        return c;
    endfunction

    function automatic ctrl_t fetchVals(input logic [2:0] st);
        ctrl_t c = idle(st);
        c.irWre = 1'b1;
        c.insMemRw = 1'b1;
        return c;
    endfunction

    // Reference: the cycle-by-cycle control word sequence of one instruction, by instruction class.
    function automatic void build(input logic [5:0] op, input logic z);
        ctrl_t c;
        bit al = op inside {ADD, SUB, ORI, SLT};
        seq.delete();
        seq.push_back(fetchVals(3'b000));
        c = idle(3'b001);
        if (op == J || op == JAL) begin c.pcWre = 1; c.pcSrc = 2'b10; end
        if (op == JAL) begin c.regWre = 1; c.regDst = 2'd0; end
        if (!(al || op inside {SW, LW, BEQ, J, JAL, HALT})) c.pcWre = 1;
        seq.push_back(c);
        if (al) begin
            c = idle(3'b110);
            c.aluOp = op == SUB ? 3'd1 : op == ORI ? 3'd3 : op == SLT ? 3'd6 : 3'd0;
            c.aluSrcB = op == ORI;
            c.extSel = op != ORI;
            seq.push_back(c);
            c.st = 3'b111; c.regWre = 1; c.wrRegData = 1; c.pcWre = 1;
            c.regDst = op == ORI ? 2'd1 : 2'd2;
            seq.push_back(c);
        end else if (op == BEQ) begin
            c = idle(3'b101);
            c.aluOp = 3'd1; c.pcWre = 1; c.pcSrc = z ? 2'b01 : 2'b00;
            seq.push_back(c);
        end else if (op == SW || op == LW) begin
            c = idle(3'b010);
            c.aluSrcB = 1;
            seq.push_back(c);
            c.st = 3'b011;
            if (op == SW) begin c.dataMemRw = 1; c.pcWre = 1; end
            seq.push_back(c);
            if (op == LW) begin
                c.st = 3'b100; c.regWre = 1; c.wrRegData = 1; c.dbDataSrc = 1; c.pcWre = 1;
                seq.push_back(c);
            end
        end
    endfunction

    // Called #1 after the edge that entered sIF; returns #1 after the edge that re-enters sIF.
    task automatic issue(input logic [5:0] op, input logic z);
        build(op, z);
        foreach (seq[i]) q.push_back(seq[i]);
        bus.Opcode = op;
        bus.Zero = z;
        repeat (seq.size()) @(posedge CLK);
        #1;
    endtask

    always @(negedge CLK) begin
        ctrl_t act, exp;
        if (q.size() > 0) begin
            exp = q.pop_front();
            act = '{bus.State, bus.PCWre, bus.IRWre, bus.InsMemRW, bus.RegWre, bus.WrRegData,
                    bus.RegDst, bus.ExtSel, bus.ALUSrcB, bus.ALUOp, bus.DataMemRW, bus.DBDataSrc,
                    bus.PCSrc};
            checks++;
            if (act !== exp) begin
                errors++;
                $display("FAIL ctrl t=%0t op=%b zero=%b got=%h expected=%h", $time, bus.Opcode,
                         bus.Zero, act, exp);
            end
        end
    end

    initial begin
        logic [5:0] pool[10] = '{ADD, SUB, ORI, SLT, SW, LW, BEQ, J, JAL, HALT};
        logic [5:0] op;
        bus.Opcode = ADD;
        bus.Zero = 1'b0;
        @(posedge CLK); #1;
        q.push_back(fetchVals(3'b000));
        @(posedge CLK); #1;
        Reset = 1'b0;
        issue(ADD, 1'b0);
        issue(LW, 1'b0);
        issue(SW, 1'b1);
        issue(BEQ, 1'b1);
        issue(BEQ, 1'b0);
        issue(JAL, 1'b0);
        issue(ORI, 1'b1);
        repeat (5) issue(HALT, 1'b0);
        issue(6'b101010, 1'b0);
        issue(SUB, 1'b0);
        issue(SLT, 1'b1);
        issue(J, 1'b1);
        // lw interrupted by a two-cycle reset while in sMEM
        build(LW, 1'b0);
        for (int i = 0; i < 3; i++) q.push_back(seq[i]);
        bus.Opcode = LW;
        repeat (3) @(posedge CLK);
        #1;
        Reset = 1'b1;
        q.push_back(fetchVals(3'b011));
        q.push_back(fetchVals(3'b000));
        repeat (2) @(posedge CLK);
        #1;
        Reset = 1'b0;
        issue(ADD, 1'b0);
        for (int n = 0; n < 150; n++) begin
            op = $urandom_range(0, 11) >= 10 ? 6'($urandom) : pool[$urandom_range(0, 9)];
            issue(op, 1'($urandom));
        end
        @(negedge CLK);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain got=%0d pending expected=0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
